// File: rtl/gate_chk_pkg.sv
// Shared types and gate-bit indices for the 2-input gate-bank checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_t;

  localparam int GATE_W     = 7;
  localparam int GATE_NOT_A = 6;
  localparam int GATE_OR    = 5;
  localparam int GATE_AND   = 4;
  localparam int GATE_NOR   = 3;
  localparam int GATE_NAND  = 2;
  localparam int GATE_XOR   = 1;
  localparam int GATE_XNOR  = 0;

endpackage

// File: rtl/gate_chk_ref.sv
// Combinational golden model of the gate bank: a[1] = A, a[0] = B.
module gate_chk_ref
  import gate_chk_pkg::*;
(
  input  logic [1:0]        a,
  output logic [GATE_W-1:0] exp
);

  always_comb begin
    exp             = '0;
    exp[GATE_NOT_A] = ~a[1];
    exp[GATE_OR]    = a[1] | a[0];
    exp[GATE_AND]   = a[1] & a[0];
    exp[GATE_NOR]   = ~(a[1] | a[0]);
    exp[GATE_NAND]  = ~(a[1] & a[0]);
    exp[GATE_XOR]   = a[1] ^ a[0];
    exp[GATE_XNOR]  = ~(a[1] ^ a[0]);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// One-shot 4-vector sweep of a 2-input gate bank against gate_chk_ref.
// Optional first-mismatch capture ports: define GATE_CHK_FIRST_ERR_EN.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_CNT_W     = 8
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [1:0]           entrada_o,
  input  logic [GATE_W-1:0]    gate_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           fail_vec,
`ifdef GATE_CHK_FIRST_ERR_EN
  output logic [1:0]           first_err_vec,
  output logic [GATE_W-1:0]    first_err_gates,
`endif
  output gate_chk_state_t      dbg_state
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PASSES - 1);

  gate_chk_state_t      r_state;
  logic [1:0]           r_vec;
  logic [SC_W-1:0]      r_settle_cnt;
  logic [PC_W-1:0]      r_pass_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ERR_CNT_W-1:0] r_err;
  logic [3:0]           r_fail;
`ifdef GATE_CHK_FIRST_ERR_EN
  logic [1:0]           r_first_vec;
  logic [GATE_W-1:0]    r_first_gates;
`endif

  logic [GATE_W-1:0]    w_exp;
  logic                 w_mismatch;
  logic [ERR_CNT_W-1:0] w_err_upd;

  gate_chk_ref u_ref (
    .a   (r_vec),
    .exp (w_exp)
  );

  // gate_i only reaches state through the SAMPLE branch, so X elsewhere is harmless.
  always_comb begin
    w_mismatch = (gate_i != w_exp);
    w_err_upd  = r_err;
    if (w_mismatch && (r_err != '1))
      w_err_upd = r_err + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_vec         <= 2'd0;
      r_settle_cnt  <= '0;
      r_pass_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err         <= '0;
      r_fail        <= 4'b0000;
`ifdef GATE_CHK_FIRST_ERR_EN
      r_first_vec   <= 2'd0;
      r_first_gates <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state       <= SETTLE;
            r_vec         <= 2'd0;
            r_settle_cnt  <= '0;
            r_pass_cnt    <= '0;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_err         <= '0;
            r_fail        <= 4'b0000;
`ifdef GATE_CHK_FIRST_ERR_EN
            r_first_vec   <= 2'd0;
            r_first_gates <= '0;
`endif
          end
        end
        SETTLE: begin
          if (r_settle_cnt == SC_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + SC_W'(1);
          end
        end
        SAMPLE: begin
          r_err <= w_err_upd;
          if (w_mismatch)
            r_fail[r_vec] <= 1'b1;
`ifdef GATE_CHK_FIRST_ERR_EN
          // An empty error count means this is the first mismatch of the sweep.
          if (w_mismatch && (r_err == '0)) begin
            r_first_vec   <= r_vec;
            r_first_gates <= gate_i;
          end
`endif
          if (r_vec != 2'd3) begin
            r_vec   <= r_vec + 2'd1;
            r_state <= SETTLE;
          end else if (r_pass_cnt != PC_LAST) begin
            r_vec      <= 2'd0;
            r_pass_cnt <= r_pass_cnt + PC_W'(1);
            r_state    <= SETTLE;
          end else begin
            r_vec   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_upd == '0);
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign entrada_o = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;
  assign dbg_state = r_state;
`ifdef GATE_CHK_FIRST_ERR_EN
  assign first_err_vec   = r_first_vec;
  assign first_err_gates = r_first_gates;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: three checker instances driven by a modelled gate bank with injectable faults.
module tb_gate_vector_checker;
  import gate_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_r;
  int         fault_mode;
  int         tests_run;
  int         tests_failed;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: PASSES=3, SETTLE_CYCLES=1. Instance 2: ERR_CNT_W=2, PASSES=2.
  logic [1:0] e0, e1, e2;
  logic [6:0] g0, g1, g2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] fail0, fail1, fail2;
  gate_chk_state_t st0, st1, st2;
`ifdef GATE_CHK_FIRST_ERR_EN
  logic [1:0] fev0, fev1, fev2;
  logic [6:0] feg0, feg1, feg2;
`endif

  function automatic logic [6:0] golden(input logic [1:0] v);
    logic a, b;
    a = v[1];
    b = v[0];
    return {~a, a | b, a & b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b)};
  endfunction

  // 1: XOR stuck-at-0, 2: NAND inverted, 3: all outputs 0, 4: AND stuck-at-1
  function automatic logic [6:0] bank(input logic [1:0] v, input int mode);
    logic [6:0] g;
    g = golden(v);
    case (mode)
      1: g[1] = 1'b0;
      2: g[2] = ~g[2];
      3: g = 7'h00;
      4: g[4] = 1'b1;
      default: ;
    endcase
    return g;
  endfunction

  always_comb begin
    g0 = bank(e0, fault_mode);
    g1 = bank(e1, fault_mode);
    g2 = bank(e2, fault_mode);
  end

  gate_vector_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .entrada_o(e0), .gate_i(g0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0),
`ifdef GATE_CHK_FIRST_ERR_EN
    .first_err_vec(fev0), .first_err_gates(feg0),
`endif
    .dbg_state(st0)
  );

  gate_vector_checker #(.SETTLE_CYCLES(1), .PASSES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .entrada_o(e1), .gate_i(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1),
`ifdef GATE_CHK_FIRST_ERR_EN
    .first_err_vec(fev1), .first_err_gates(feg1),
`endif
    .dbg_state(st1)
  );

  gate_vector_checker #(.ERR_CNT_W(2), .PASSES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .entrada_o(e2), .gate_i(g2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2),
`ifdef GATE_CHK_FIRST_ERR_EN
    .first_err_vec(fev2), .first_err_gates(feg2),
`endif
    .dbg_state(st2)
  );

  function automatic logic done_of(input int idx);
    case (idx)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Leaves the bench #1 after the accepting edge, i.e. in cycle 1 of the sweep.
  task automatic pulse_start(input int idx);
    @(negedge clk);
    start_r[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_r[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (done_of(idx) !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_r = 3'b000;
    fault_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({e0, busy0, done0, pass0} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got entrada=%b busy=%b done=%b pass=%b, want all 0", e0, busy0, done0, pass0);
    end
    tests_run++;
    if (err0 !== 8'd0 || fail0 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_cnt: got err=%0d fail_vec=%b, want 0 / 0000", err0, fail0);
    end
    tests_run++;
    if (st0 !== IDLE || st1 !== IDLE || st2 !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d/%0d/%0d, want IDLE", st0, st1, st2);
    end
`ifdef GATE_CHK_FIRST_ERR_EN
    tests_run++;
    if (fev0 !== 2'd0 || feg0 !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset_first_err: got vec=%0d gates=%h, want 0/00", fev0, feg0);
    end
`endif
  endtask

  task automatic test_golden_sweep();
    fault_mode = 0;
    pulse_start(0);
    for (int k = 1; k <= 12; k++) begin
      tests_run++;
      if (e0 !== 2'((k - 1) / 3) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL golden_cycle%0d: got entrada=%b busy=%b done=%b, want entrada=%0d busy=1 done=0",
                 k, e0, busy0, done0, (k - 1) / 3);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || e0 !== 2'b00) begin
      tests_failed++;
      $display("FAIL golden_done13: got done=%b busy=%b entrada=%b, want 1/0/00", done0, busy0, e0);
    end
    tests_run++;
    if (pass0 !== 1'b1 || err0 !== 8'd0 || fail0 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL golden_result: got pass=%b err=%0d fail_vec=%b, want 1/0/0000", pass0, err0, fail0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done0 !== 1'b0 || pass0 !== 1'b1 || st0 !== IDLE) begin
      tests_failed++;
      $display("FAIL golden_after: got done=%b pass=%b state=%0d, want 0/1/IDLE", done0, pass0, st0);
    end
  endtask

  task automatic test_xor_stuck();
    int cyc;
    fault_mode = 1;
    pulse_start(0);
    wait_done(0, 1, cyc);
    tests_run++;
    if (cyc != 13) begin
      tests_failed++;
      $display("FAIL xor_latency: got done at cycle %0d, want 13", cyc);
    end
    tests_run++;
    if (err0 !== 8'd2 || fail0 !== 4'b0110 || pass0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL xor_result: got err=%0d fail_vec=%b pass=%b, want 2/0110/0", err0, fail0, pass0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_passes_nand();
    int cyc;
    fault_mode = 2;
    pulse_start(1);
    wait_done(1, 1, cyc);
    tests_run++;
    if (cyc != 25) begin
      tests_failed++;
      $display("FAIL nand_latency: got done at cycle %0d, want 25", cyc);
    end
    tests_run++;
    if (err1 !== 8'd12 || fail1 !== 4'b1111 || pass1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL nand_result: got err=%0d fail_vec=%b pass=%b, want 12/1111/0", err1, fail1, pass1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_err_saturate();
    int cyc;
    fault_mode = 3;
    pulse_start(2);
    wait_done(2, 1, cyc);
    tests_run++;
    if (cyc != 25) begin
      tests_failed++;
      $display("FAIL sat_latency: got done at cycle %0d, want 25", cyc);
    end
    tests_run++;
    if (err2 !== 2'd3 || fail2 !== 4'b1111 || pass2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_result: got err=%0d fail_vec=%b pass=%b, want 3/1111/0", err2, fail2, pass2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    int done_seen;
    fault_mode = 0;
    pulse_start(0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (e0 !== 2'b01 || busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midsweep_pre: got entrada=%b busy=%b at cycle 5, want 01/1", e0, busy0);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (e0 !== 2'b00 || busy0 !== 1'b0 || st0 !== IDLE || done0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got entrada=%b busy=%b state=%0d done=%b, want 00/0/IDLE/0", e0, busy0, st0, done0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done0 === 1'b1) done_seen++;
    end
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL no_done_after_abort: got %0d done pulses, want 0", done_seen);
    end
    pulse_start(0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    wait_done(0, 4, cyc);
    tests_run++;
    if (cyc != 13 || pass0 !== 1'b1 || err0 !== 8'd0) begin
      tests_failed++;
      $display("FAIL restart: got done cycle=%0d pass=%b err=%0d, want 13/1/0", cyc, pass0, err0);
    end
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    tests_run++;
    if (busy0 !== 1'b0 || st0 !== IDLE) begin
      tests_failed++;
      $display("FAIL start_in_done: got busy=%b state=%0d, want 0/IDLE", busy0, st0);
    end
  endtask

`ifdef GATE_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    int cyc;
    fault_mode = 4;
    pulse_start(0);
    wait_done(0, 1, cyc);
    tests_run++;
    if (err0 !== 8'd3 || fail0 !== 4'b0111) begin
      tests_failed++;
      $display("FAIL and_result: got err=%0d fail_vec=%b, want 3/0111", err0, fail0);
    end
    tests_run++;
    if (fev0 !== 2'b00 || feg0 !== 7'h5D) begin
      tests_failed++;
      $display("FAIL first_err_done: got vec=%0d gates=%h, want 0/5d", fev0, feg0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (fev0 !== 2'b00 || feg0 !== 7'h5D) begin
      tests_failed++;
      $display("FAIL first_err_held: got vec=%0d gates=%h, want 0/5d", fev0, feg0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_golden_sweep();
    test_xor_stuck();
    test_passes_nand();
    test_err_saturate();
    test_reset_mid_sweep();
`ifdef GATE_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
